// File: rtl/result_accum_buffer.sv
// Groups consecutive adder results into sums of N samples and queues each
// {sum, count} in a circular FIFO drained through a ready/valid port.
module result_accum_buffer #(
    parameter  int W     = 20,
    parameter  int N     = 4,
    parameter  int DEPTH = 4,
    localparam int SW    = W + $clog2(N),
    localparam int CW    = $clog2(N + 1),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_sum,
    output logic [CW-1:0] out_count,
    output logic [LW-1:0] level,
    output logic          overflow
);
    localparam int PW = $clog2(DEPTH);

    logic [SW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;

    logic [SW-1:0] sum_mem [DEPTH];
    logic [CW-1:0] cnt_mem [DEPTH];

    logic [SW-1:0] grp_sum;
    logic [CW-1:0] grp_cnt;
    logic          push, pop, accept;

    // Output handshake: the head entry transfers on any rising edge where
    // out_valid && out_ready; the head holds steady while out_ready is low.
    // The input side has no backpressure: every in_valid sample is taken.
    always_comb begin
        grp_sum    = acc_q + (in_valid ? SW'(in_data) : '0);
        grp_cnt    = cnt_q + CW'(in_valid);
        push       = (grp_cnt == CW'(N)) || (flush && (grp_cnt != '0));
        pop        = (level_q != '0) && out_ready;
        accept     = push && ((level_q < LW'(DEPTH)) || pop);

        acc_d      = acc_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q + LW'(accept) - LW'(pop);
        overflow_d = overflow_q | (push && !accept);

        // The group closes whether or not the FIFO had room for it.
        if (push) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_valid) begin
            acc_d = grp_sum;
            cnt_d = grp_cnt;
        end

        if (pop)
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        if (accept)
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only visible while level is nonzero.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            sum_mem[wr_ptr_q] <= grp_sum;
            cnt_mem[wr_ptr_q] <= grp_cnt;
        end
    end

    assign out_valid = (level_q != '0);
    assign out_sum   = out_valid ? sum_mem[rd_ptr_q] : '0;
    assign out_count = out_valid ? cnt_mem[rd_ptr_q] : '0;
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_accum_buffer.sv
// Bench for result_accum_buffer: directed scenarios plus a randomized run
// against a queue-based model of grouping and FIFO occupancy.
module tb_result_accum_buffer;
    localparam int W     = 20;
    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int SW    = W + $clog2(N);
    localparam int CW    = $clog2(N + 1);
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic [LW-1:0] level;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: pending samples, queued groups, sticky overflow.
    logic [W-1:0]  part_q[$];
    logic [SW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt_q[$];
    bit            exp_ovf = 1'b0;

    result_accum_buffer #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .level(level),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, then settle past the edge.
    task automatic step(input bit v, input logic [W-1:0] d, input bit f,
                        input bit r, input bit rs);
        logic [SW-1:0] s;
        bit do_pop;
        rst = rs; in_valid = v; in_data = d; flush = f; out_ready = r;
        if (rs) begin
            part_q.delete(); exp_q.delete(); exp_cnt_q.delete(); exp_ovf = 1'b0;
        end else begin
            do_pop = r && (exp_q.size() > 0);
            if (v) part_q.push_back(d);
            if (do_pop) begin
                void'(exp_q.pop_front());
                void'(exp_cnt_q.pop_front());
            end
            if (part_q.size() == N || (f && part_q.size() > 0)) begin
                s = '0;
                foreach (part_q[i]) s += SW'(part_q[i]);
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back(s);
                    exp_cnt_q.push_back(CW'(part_q.size()));
                end else begin
                    exp_ovf = 1'b1;
                end
                part_q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 20'd7, 1'b0, 1'b1, 1'b1);
        step(1'b1, 20'd7, 1'b0, 1'b1, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", out_valid); end
        checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_sum got %0d exp 0", out_sum); end
        checks++; if (out_count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", out_count); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0d exp 0", overflow); end
    endtask

    task automatic test_full_group();
        for (int i = 1; i <= 3; i++) step(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL group_early_valid got %0d exp 0", out_valid); end
        step(1'b1, 20'd4, 1'b0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL group_valid got %0d exp 1", out_valid); end
        checks++; if (out_sum !== 22'd10) begin errors++; $display("FAIL group_sum got %0d exp 10", out_sum); end
        checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL group_count got %0d exp 4", out_count); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL group_drained got %0d exp 0", out_valid); end
    endtask

    task automatic test_max_width();
        for (int i = 0; i < N; i++) step(1'b1, 20'hFFFFF, 1'b0, 1'b1, 1'b0);
        checks++; if (out_sum !== 22'h3FFFFC) begin errors++; $display("FAIL maxw_sum got %h exp 3ffffc", out_sum); end
        checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL maxw_count got %0d exp 4", out_count); end
        for (int i = 0; i < N; i++) step(1'b1, 20'd1, 1'b0, 1'b1, 1'b0);
        checks++; if (out_sum !== 22'd4) begin errors++; $display("FAIL maxw_next_sum got %0d exp 4", out_sum); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        step(1'b1, 20'd5, 1'b0, 1'b1, 1'b0);
        step(1'b1, 20'd6, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        checks++; if (out_sum !== 22'd11) begin errors++; $display("FAIL flush_sum got %0d exp 11", out_sum); end
        checks++; if (out_count !== 3'd2) begin errors++; $display("FAIL flush_count got %0d exp 2", out_count); end
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL flush_empty_level got %0d exp 0", level); end
        for (int i = 0; i < 3; i++) step(1'b1, 20'd1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 20'd9, 1'b1, 1'b1, 1'b0);
        checks++; if (out_sum !== 22'd12) begin errors++; $display("FAIL flush_nth_sum got %0d exp 12", out_sum); end
        checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL flush_nth_count got %0d exp 4", out_count); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL flush_nth_level got %0d exp 1", level); end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5 * N; i++) step(1'b1, 20'd1, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0d exp 1", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (out_valid !== 1'b1 || out_sum !== 22'd4) begin errors++; $display("FAIL ovf_head%0d got v=%0d s=%0d exp v=1 s=4", i, out_valid, out_sum); end
            step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL ovf_drain_level got %0d exp 0", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0d exp 1", overflow); end
    endtask

    task automatic test_full_pop();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int g = 1; g <= DEPTH + 1; g++)
            for (int i = 0; i < N; i++)
                step(1'b1, W'(g), 1'b0, (g == DEPTH + 1 && i == N - 1), 1'b0);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpop_level got %0d exp 4", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got %0d exp 0", overflow); end
        for (int g = 2; g <= DEPTH + 1; g++) begin
            checks++; if (out_sum !== SW'(4 * g)) begin errors++; $display("FAIL fullpop_order got %0d exp %0d", out_sum, 4 * g); end
            step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_random();
        bit v, f, r;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 2) != 0) || (c > 380);
            step(v, W'($urandom), f, r, 1'b0);
            checks++; if (level !== LW'(exp_q.size())) begin errors++; $display("FAIL rand_level c=%0d got %0d exp %0d", c, level, exp_q.size()); end
            checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rand_overflow c=%0d got %0d exp %0d", c, overflow, exp_ovf); end
            checks++; if (out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rand_valid c=%0d got %0d", c, out_valid); end
            if (exp_q.size() > 0) begin
                checks++; if (out_sum !== exp_q[0] || out_count !== exp_cnt_q[0]) begin errors++; $display("FAIL rand_head c=%0d got %0d/%0d exp %0d/%0d", c, out_sum, out_count, exp_q[0], exp_cnt_q[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_max_width();
        test_flush();
        test_overflow();
        test_full_pop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_accum_buffer.md
# result_accum_buffer

Downstream consumer of the pipelined adder stage. It takes the adder's result stream (`y` qualified by `valid`), accumulates consecutive results into groups of N, and queues each group sum in a small FIFO. The FIFO drains through a ready/valid output port. The adder stage has no backpressure, so this block absorbs results every cycle and reports any loss through a sticky overflow flag.

## Interface
- `W`, default 20: width of incoming result samples; matches the adder stage width.
- `N`, default 4: number of samples per group; must be ≥ 2.
- `DEPTH`, default 4: number of FIFO entries; must be ≥ 2.
- Derived `SW` = W + $clog2(N): sum width.
- Derived `CW` = $clog2(N+1): group count width.
- Derived `LW` = $clog2(DEPTH+1): FIFO level width.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: sample strobe; connects to the adder's `valid`.
- `in_data`  in  W: sample value; connects to the adder's `y`.
- `flush`  in  1: close the current partial group.
- `out_valid`  out  1: FIFO head is valid.
- `out_ready`  in  1: consumer accepts the head.
- `out_sum`  out  SW: group sum at the FIFO head.
- `out_count`  out  CW: number of samples in the head group (1..N).
- `level`  out  LW: FIFO occupancy (0..DEPTH).
- `overflow`  out  1: sticky flag; a completed group was dropped.

## Operation
- Accumulator holds `acc` (SW bits) and `cnt` (CW bits). It is idle when cnt = 0 and accumulating when 1 ≤ cnt ≤ N−1.
- `in_valid` = 1 and cnt+1 < N: set acc ← acc + in_data and cnt ← cnt+1.
- `in_valid` = 1 and cnt+1 = N: the group completes.
  - Push {acc + in_data, N} to the FIFO.
  - Set acc ← 0 and cnt ← 0.
- `flush` = 1: the group completes with whatever has accumulated.
  - The same-cycle sample, if `in_valid` = 1, is included in the group.
  - Push {acc + in_data·in_valid, cnt + in_valid} if that count is > 0, then clear acc and cnt.
  - If the count is 0, nothing is pushed.
- `flush` in the same cycle that the Nth sample arrives pushes exactly one group of N.
- Arithmetic is unsigned and zero-extended to SW bits. Wrap is impossible because N·(2^W−1) < 2^SW.
- FIFO is circular with DEPTH entries. Each entry holds {sum, count}.
  - Pop occurs when `out_valid` && `out_ready`.
  - Push is accepted when level < DEPTH, or when a pop happens in the same cycle.
  - A push to a full FIFO with no same-cycle pop drops the group, sets `overflow` to 1, and leaves FIFO contents unchanged.
  - The accumulator clears regardless of whether the push was accepted or dropped.
- Simultaneous push and pop leaves level unchanged. Read and write pointers both advance, with wrap at DEPTH−1 → 0.
- Pop with empty FIFO cannot occur, because `out_valid` = 0 when the FIFO is empty.
- `overflow` clears only on `rst`.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Reset values: `out_valid` = 0, `out_sum` = 0, `out_count` = 0, `level` = 0, `overflow` = 0. Internal acc, cnt and both FIFO pointers are also reset to 0.
- `rst` asserted during an operation discards the partial group and all FIFO contents on the next edge. Inputs in the reset cycle are ignored.
- Latency: a group completing at edge t is visible with `out_valid` = 1 after edge t (same edge as the push).
  - Counted from the adder's inputs: start at cycle c gives `y`/`valid` at c+2, and the FIFO head for group completion at c+3.
- The block sustains one sample per cycle indefinitely while `out_ready` = 1.
- `out_sum` and `out_count` stay stable while `out_valid` = 1 and `out_ready` = 0.

## Test plan
- **Reset:** hold `rst` = 1 for 2 cycles with `in_valid` = 1 and `in_data` = 7. Required: all outputs 0. After release, the first group sums only post-reset samples.
- **Full group:** with `out_ready` = 1, send 1, 2, 3, 4 on consecutive cycles. Required: one cycle with `out_valid` = 1, `out_sum` = 10, `out_count` = 4, then `out_valid` = 0.
- **Max width:** send four samples of 0xFFFFF. Required: `out_sum` = 0x3FFFFC (22 bits), `out_count` = 4. The next group starts from 0.
- **Flush cases:**
  - Send 5, 6, then pulse `flush` alone. Required: `out_sum` = 11, `out_count` = 2.
  - Pulse `flush` with cnt = 0 and `in_valid` = 0. Required: no push.
  - Send 9 with `flush` high while cnt = 3 and acc = 3. Required: `out_sum` = 12, `out_count` = 4.
- **Backpressure and overflow:** with `out_ready` = 0, send 5 groups of four 1s. Required: `level` = 4, 5th group dropped, `overflow` = 1. Then raise `out_ready`: four heads of sum 4 drain in order, `level` reaches 0, and `overflow` stays 1.
- **Full plus simultaneous pop:** with `level` = 4 and `out_ready` = 1, complete a group in the same cycle as a pop. Required: group accepted, `level` stays 4, `overflow` stays 0, FIFO order preserved across pointer wrap.
